alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1  operation request per requester (0 = core pipeline, 1 = address unit).
REQ-005 SHALL have ports op0/op1  input  4  opcode: 0000 ADD, 0001 PADDSB, 0010 SUB, 0011 AND, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 LW (address add); 1001-1111 illegal.
REQ-006 SHALL have ports a0/a1, b0/b1  input  16  operands; shamt0/shamt1  input  4  shift amount.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle accept pulse; operands sampled on that edge.
REQ-008 SHALL have ports rsp_vld  output  1; rsp_id  output  1; rsp_dst  output  16; rsp_err  output  1; rsp_rdy  input  1.
REQ-009 SHALL have ports flag_ov, flag_zr, flag_neg  output  1  architectural flag register.

Function
REQ-010 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-011 IDLE: if any req, SHALL assert exactly one gnt combinationally, latch op/a/b/shamt/id, go EXEC; else stay.
REQ-012 gnt SHALL be 0 in EXEC and RESP; requesters hold req and operands until gnt.
REQ-013 EXEC: SHALL drive the ALU from latched operands (op decoded to func[2:0]/paddsb/llb; LW = ADD), register dst and ALU flags, go RESP.
REQ-014 RESP: rsp_vld=1 with stable rsp_id/rsp_dst/rsp_err until rsp_rdy=1; on rsp_vld&rsp_rdy go IDLE.
REQ-015 Latency: gnt at cycle N -> rsp_vld first high at N+2; minimum 3 cycles per op.
REQ-016 Flags SHALL update at EXEC->RESP only when id=0 and op in 0000-0111; ov written only for ADD/PADDSB/SUB, cleared to 0 for other ops; zr = (dst==0); neg = dst[15].
REQ-017 Requester 1 ops and LW SHALL leave flags unchanged.
REQ-018 Illegal opcode: rsp_dst=0x0000, rsp_err=1, flags unchanged; otherwise rsp_err=0.
REQ-019 Arithmetic SHALL be 16-bit with ADD/SUB saturating per ALU semantics; shifts use shamt 0-15.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, gnt0/gnt1=0, rsp_vld=0, rsp_id=0, rsp_dst=0, rsp_err=0, all flags=0, arbitration pointer=0.
REQ-021 Reset during EXEC/RESP SHALL discard the in-flight op with no response and no flag update.

Configuration
REQ-022 With ALU_ARB_RR_EN defined: round-robin; pointer toggles to the other requester after each grant; on simultaneous req the requester not last granted wins; after reset requester 0 wins.
REQ-023 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins ties.

Structure
REQ-024 alu_pkg SHALL hold opcode constants, FSM state enum, and decode-to-func mapping constants.
REQ-025 SHALL instantiate the existing alu module as its single sub-module; no other sub-modules.

Verification
REQ-026 req0 ADD a=0x7FFF b=0x0001, rsp_rdy=1 -> gnt0 at N, rsp_vld at N+2, rsp_dst=0x7FFF (saturated), flag_ov=1, flag_zr=0, flag_neg=0.
REQ-027 req1 SUB 0x0005-0x0005 after flags ov=1 -> rsp_dst=0x0000, rsp_id=1, flags unchanged.
REQ-028 req0 and req1 held high (RR_EN) -> grants alternate 0,1,0,1; without RR_EN -> gnt0 every op, gnt1 never.
REQ-029 rsp_rdy low 4 cycles in RESP -> rsp_vld and rsp_dst held stable, no gnt; rsp_rdy high -> IDLE next cycle.
REQ-030 req0 op=1010 -> rsp_err=1, rsp_dst=0x0000, flags unchanged.
REQ-031 rst_n low during EXEC -> all outputs 0 immediately, no rsp_vld after release, next req granted from IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states and the opcode-to-ALU decode.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_PADDSB = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_AND    = 4'b0011;
    localparam logic [3:0] OP_NOR    = 4'b0100;
    localparam logic [3:0] OP_SLL    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;

    localparam logic [2:0] FUNC_ADD    = 3'd0;
    localparam logic [2:0] FUNC_PADDSB = 3'd1;
    localparam logic [2:0] FUNC_SUB    = 3'd2;
    localparam logic [2:0] FUNC_AND    = 3'd3;
    localparam logic [2:0] FUNC_NOR    = 3'd4;
    localparam logic [2:0] FUNC_SLL    = 3'd5;
    localparam logic [2:0] FUNC_SRL    = 3'd6;
    localparam logic [2:0] FUNC_SRA    = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    typedef struct packed {
        logic [2:0] func;
        logic       paddsb;
        logic       llb;
        logic       legal;
        logic       sets_flags;
        logic       sets_ov;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '{func: FUNC_ADD, paddsb: 1'b0, llb: 1'b0, legal: 1'b0, sets_flags: 1'b0,
              sets_ov: 1'b0};
        if (op[3] == 1'b0) begin
            d.func       = op[2:0];
            d.paddsb     = (op == OP_PADDSB);
            d.legal      = 1'b1;
            d.sets_flags = 1'b1;
            d.sets_ov    = (op == OP_ADD) || (op == OP_PADDSB) || (op == OP_SUB);
        end else if (op == OP_LW) begin
            // Address add: same adder, never touches the flag register.
            d.func  = FUNC_ADD;
            d.legal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit ALU: saturating add/sub, nibble-wise saturating PADDSB, logic ops and shifts.
module alu
    import alu_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [3:0]  shamt_i,
    input  logic [2:0]  func_i,
    input  logic        paddsb_i,
    input  logic        llb_i,
    output logic [15:0] dst_o,
    output logic        ov_o
);

    logic [15:0] sum, diff, nib;
    logic        sum_ov, diff_ov, nib_ov;

    always_comb begin
        sum     = a_i + b_i;
        diff    = a_i - b_i;
        sum_ov  = (a_i[15] == b_i[15]) && (sum[15] != a_i[15]);
        diff_ov = (a_i[15] != b_i[15]) && (diff[15] != a_i[15]);
        nib     = '0;
        nib_ov  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ns;
            ns = a_i[4*i +: 4] + b_i[4*i +: 4];
            if ((a_i[4*i+3] == b_i[4*i+3]) && (ns[3] != a_i[4*i+3])) begin
                nib[4*i +: 4] = a_i[4*i+3] ? 4'h8 : 4'h7;
                nib_ov        = 1'b1;
            end else begin
                nib[4*i +: 4] = ns;
            end
        end
    end

    always_comb begin
        dst_o = '0;
        ov_o  = 1'b0;
        unique case (func_i)
            FUNC_ADD, FUNC_PADDSB: begin
                if (paddsb_i) begin
                    dst_o = nib;
                    ov_o  = nib_ov;
                end else begin
                    dst_o = sum_ov ? (a_i[15] ? 16'h8000 : 16'h7FFF) : sum;
                    ov_o  = sum_ov;
                end
            end
            FUNC_SUB: begin
                dst_o = diff_ov ? (a_i[15] ? 16'h8000 : 16'h7FFF) : diff;
                ov_o  = diff_ov;
            end
            FUNC_AND: dst_o = a_i & b_i;
            FUNC_NOR: dst_o = ~(a_i | b_i);
            FUNC_SLL: dst_o = a_i << shamt_i;
            FUNC_SRL: dst_o = a_i >> shamt_i;
            FUNC_SRA: dst_o = $signed(a_i) >>> shamt_i;
            default:  dst_o = '0;
        endcase
        if (llb_i) begin
            dst_o = {a_i[15:8], b_i[7:0]};
        end
    end

endmodule

// File: rtl/alu_arb.sv
// Two-requester front end to a shared ALU with a 3-cycle IDLE/EXEC/RESP handshake.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arb
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  op0,
    input  logic [3:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] a1,
    input  logic [15:0] b0,
    input  logic [15:0] b1,
    input  logic [3:0]  shamt0,
    input  logic [3:0]  shamt1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_vld,
    output logic        rsp_id,
    output logic [15:0] rsp_dst,
    output logic        rsp_err,
    input  logic        rsp_rdy,
    output logic        flag_ov,
    output logic        flag_zr,
    output logic        flag_neg
);

    localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e         state_q, state_d;
    logic [3:0]     op_q, op_d, shamt_q, shamt_d;
    logic [15:0]    a_q, a_d, b_q, b_d, dst_q, dst_d;
    logic [IdW-1:0] id_q, id_d;
    logic           err_q, err_d, ov_q, ov_d, zr_q, zr_d, neg_q, neg_d;
    logic           pick1, gnt_any;
    logic [15:0]    alu_dst;
    logic           alu_ov;
    dec_t           dec;

`ifdef ALU_ARB_RR_EN
    // ptr_q set means requester 1 wins a tie.
    logic ptr_q, ptr_d;

    assign pick1 = req1 && (!req0 || ptr_q);
    assign ptr_d = gnt_any ? !pick1 : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick1 = req1 && !req0;
`endif

    assign dec = decode(op_q);

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .shamt_i  (shamt_q),
        .func_i   (dec.func),
        .paddsb_i (dec.paddsb),
        .llb_i    (dec.llb),
        .dst_o    (alu_dst),
        .ov_o     (alu_ov)
    );

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rsp_vld = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((req0 || req1) && rst_n) begin
                    gnt0    = !pick1;
                    gnt1    = pick1;
                    state_d = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gnt_any = gnt0 || gnt1;

    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        shamt_d = shamt_q;
        id_d    = id_q;
        dst_d   = dst_q;
        err_d   = err_q;
        ov_d    = ov_q;
        zr_d    = zr_q;
        neg_d   = neg_q;
        if (gnt_any) begin
            op_d    = pick1 ? op1 : op0;
            a_d     = pick1 ? a1 : a0;
            b_d     = pick1 ? b1 : b0;
            shamt_d = pick1 ? shamt1 : shamt0;
            id_d    = IdW'(pick1);
        end
        if (state_q == StExec) begin
            dst_d = dec.legal ? alu_dst : 16'h0000;
            err_d = !dec.legal;
            // Only core-pipeline arithmetic/logic ops own the architectural flags.
            if (dec.sets_flags && (id_q == '0)) begin
                ov_d  = dec.sets_ov && alu_ov;
                zr_d  = (alu_dst == 16'h0000);
                neg_d = alu_dst[15];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shamt_q <= '0;
            id_q    <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            zr_q    <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shamt_q <= shamt_d;
            id_q    <= id_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            zr_q    <= zr_d;
            neg_q   <= neg_d;
        end
    end

    assign rsp_id   = id_q[0];
    assign rsp_dst  = dst_q;
    assign rsp_err  = err_q;
    assign flag_ov  = ov_q;
    assign flag_zr  = zr_q;
    assign flag_neg = neg_q;

endmodule
